// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, funct codes, ALU codes, selects and FSM states.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_HALT = 4'd15
  } state_t;
endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: maps R-type funct to an ALU operation code and flags unsupported functs.
module alu_ctl_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctl,
  output logic       o_funct_valid
);
  always_comb begin
    o_alu_ctl = i_funct == FN_ADD ? ALU_ADD :
                i_funct == FN_SUB ? ALU_SUB :
                i_funct == FN_OR  ? ALU_OR  :
                i_funct == FN_SLT ? ALU_SLT : ALU_AND;
    o_funct_valid = i_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS main control FSM driving ALU, PC, IR, memory and register file.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] alu_ctl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);
  state_t     r_state, w_next;
  logic [3:0] w_fn_ctl;
  logic       w_fn_valid, w_legal;

  alu_ctl_decode u_dec (.i_funct(funct), .o_alu_ctl(w_fn_ctl), .o_funct_valid(w_fn_valid));

  assign w_legal = opcode == OP_RTYPE ? w_fn_valid :
                   opcode inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  assign state = r_state;

  always_ff @(posedge clk)
    if (reset) r_state <= S_FETCH;
    else r_state <= w_next;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = !w_legal ? (ILLEGAL_TRAP ? S_HALT : S_FETCH) :
                         opcode == OP_RTYPE ? S_EXEC :
                         opcode inside {OP_LW, OP_SW} ? S_MEMADR :
                         opcode == OP_BEQ ? S_BRANCH :
                         opcode == OP_J ? S_JUMP : S_ADDIEX;
      S_MEMADR: w_next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Reset forces every output inactive so an aborted instruction never writes.
  always_comb begin
    alu_ctl = ALU_AND;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    pc_source = PC_ALU;
    pc_en = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    illegal = 1'b0;
    if (!reset)
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = 1'b1;
          alu_src_b = SRCB_4;
          alu_ctl = ALU_ADD;
          pc_en = 1'b1;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM2;
          alu_ctl = ALU_ADD;
          illegal = !w_legal;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctl = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord = 1'b1;
        end
        S_MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_ctl = w_fn_ctl;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctl = ALU_SUB;
          pc_source = PC_ALUOUT;
          pc_en = zero;
        end
        S_JUMP: begin
          pc_source = PC_JUMP;
          pc_en = 1'b1;
        end
        S_ADDIWB: reg_write = 1'b1;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven scoreboard bench for both illegal-instruction policies.
module tb_mips_multicycle_ctrl;
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       chk;
    logic [3:0] st;
    logic [17:0] out;
  } vec_t;

  logic clk = 1'b0;
  logic reset, reset2;
  logic [5:0] opcode, funct;
  logic zero;
  logic [3:0] alu_ctl, alu_ctl2, state, state2;
  logic alu_src_a, alu_src_a2, pc_en, pc_en2, iord, iord2, mem_read, mem_read2;
  logic mem_write, mem_write2, ir_write, ir_write2, reg_dst, reg_dst2;
  logic mem_to_reg, mem_to_reg2, reg_write, reg_write2, illegal, illegal2;
  logic [1:0] alu_src_b, alu_src_b2, pc_source, pc_source2;
  logic [17:0] w_out1, w_out2;
  vec_t tbl[$];
  vec_t sb[$];
  int errors = 0, checks = 0;
  logic [17:0] F, D, DI, MA, MR, MW, MWR, AW, AIW, J, Z;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_ctl(alu_ctl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .state(state));

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut2 (
    .clk(clk), .reset(reset2), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_ctl(alu_ctl2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .pc_source(pc_source2),
    .pc_en(pc_en2), .iord(iord2), .mem_read(mem_read2), .mem_write(mem_write2),
    .ir_write(ir_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
    .reg_write(reg_write2), .illegal(illegal2), .state(state2));

  assign w_out1 = {alu_ctl, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
                   mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};
  assign w_out2 = {alu_ctl2, alu_src_a2, alu_src_b2, pc_source2, pc_en2, iord2, mem_read2,
                   mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2, illegal2};

  function automatic logic [17:0] ex(input logic [3:0] a);
    return {a, 1'b1, 2'b00, 2'b00, 9'b0};
  endfunction

  function automatic logic [17:0] br(input logic z);
    return {4'h6, 1'b1, 2'b00, 2'b01, z, 8'b0};
  endfunction

  task automatic v(input logic rst, input logic [5:0] op, input logic [5:0] fn, input logic z,
                   input logic chk, input logic [3:0] st, input logic [17:0] out);
    vec_t e;
    e.rst = rst; e.op = op; e.fn = fn; e.z = z; e.chk = chk; e.st = st; e.out = out;
    tbl.push_back(e);
  endtask

  task automatic check(input string n, input int idx, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d got %h want %h", n, idx, got, want);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, then compare mid-cycle.
  task automatic apply(input vec_t e, input bit d2, input int idx);
    vec_t x;
    @(negedge clk);
    if (d2) reset2 = e.rst; else reset = e.rst;
    opcode = e.op; funct = e.fn; zero = e.z;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    if (x.chk) check(d2 ? "state2" : "state", idx, {14'b0, d2 ? state2 : state}, {14'b0, x.st});
    check(d2 ? "out2" : "out", idx, d2 ? w_out2 : w_out1, x.out);
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    F   = {4'h2, 1'b0, 2'b01, 2'b00, 9'b1_0_1_0_1_0_0_0_0};
    D   = {4'h2, 1'b0, 2'b11, 2'b00, 9'b0};
    DI  = D | 18'd1;
    MA  = {4'h2, 1'b1, 2'b10, 2'b00, 9'b0};
    MR  = {4'h0, 1'b0, 2'b00, 2'b00, 9'b0_1_1_0_0_0_0_0_0};
    MW  = {4'h0, 1'b0, 2'b00, 2'b00, 9'b0_0_0_0_0_0_1_1_0};
    MWR = {4'h0, 1'b0, 2'b00, 2'b00, 9'b0_1_0_1_0_0_0_0_0};
    AW  = {4'h0, 1'b0, 2'b00, 2'b00, 9'b0_0_0_0_0_1_0_1_0};
    AIW = {4'h0, 1'b0, 2'b00, 2'b00, 9'b0_0_0_0_0_0_0_1_0};
    J   = {4'h0, 1'b0, 2'b00, 2'b10, 9'b1_0_0_0_0_0_0_0_0};
    Z   = 18'b0;
    v(1, 6'h00, 6'h20, 0, 0, 4'd0, Z);
    v(1, 6'h00, 6'h20, 0, 1, 4'd0, Z);
    v(0, 6'h23, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h23, 6'h00, 0, 1, 4'd1, D);
    v(0, 6'h23, 6'h00, 0, 1, 4'd2, MA);
    v(0, 6'h23, 6'h00, 0, 1, 4'd3, MR);
    v(0, 6'h23, 6'h00, 0, 1, 4'd4, MW);
    v(0, 6'h00, 6'h2A, 0, 1, 4'd0, F);
    v(0, 6'h00, 6'h2A, 0, 1, 4'd1, D);
    v(0, 6'h00, 6'h2A, 0, 1, 4'd6, ex(4'h7));
    v(0, 6'h00, 6'h2A, 0, 1, 4'd7, AW);
    v(0, 6'h00, 6'h22, 0, 1, 4'd0, F);
    v(0, 6'h00, 6'h22, 0, 1, 4'd1, D);
    v(0, 6'h00, 6'h22, 1, 1, 4'd6, ex(4'h6));
    v(0, 6'h00, 6'h22, 0, 1, 4'd7, AW);
    v(0, 6'h04, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h04, 6'h00, 1, 1, 4'd1, D);
    v(0, 6'h04, 6'h00, 1, 1, 4'd8, br(1'b1));
    v(0, 6'h04, 6'h00, 1, 1, 4'd0, F);
    v(0, 6'h04, 6'h00, 0, 1, 4'd1, D);
    v(0, 6'h04, 6'h00, 0, 1, 4'd8, br(1'b0));
    v(0, 6'h2B, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h2B, 6'h00, 0, 1, 4'd1, D);
    v(0, 6'h2B, 6'h00, 0, 1, 4'd2, MA);
    v(0, 6'h2B, 6'h00, 0, 1, 4'd5, MWR);
    v(0, 6'h08, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h08, 6'h00, 0, 1, 4'd1, D);
    v(0, 6'h08, 6'h00, 0, 1, 4'd10, MA);
    v(0, 6'h08, 6'h00, 0, 1, 4'd11, AIW);
    v(0, 6'h02, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h02, 6'h00, 0, 1, 4'd1, D);
    v(0, 6'h02, 6'h00, 0, 1, 4'd9, J);
    v(0, 6'h3F, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h3F, 6'h00, 0, 1, 4'd1, DI);
    v(0, 6'h00, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h00, 6'h00, 0, 1, 4'd1, DI);
    v(0, 6'h2B, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h2B, 6'h00, 0, 1, 4'd1, D);
    v(0, 6'h2B, 6'h00, 0, 1, 4'd2, MA);
    v(1, 6'h2B, 6'h00, 0, 1, 4'd5, Z);
    v(0, 6'h2B, 6'h00, 0, 1, 4'd0, F);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, i);
    tbl.delete();
    v(1, 6'h3F, 6'h00, 0, 1, 4'd0, Z);
    v(0, 6'h3F, 6'h00, 0, 1, 4'd0, F);
    v(0, 6'h3F, 6'h00, 0, 1, 4'd1, DI);
    v(0, 6'h3F, 6'h00, 0, 1, 4'd15, Z);
    v(0, 6'h23, 6'h00, 1, 1, 4'd15, Z);
    v(0, 6'h00, 6'h20, 0, 1, 4'd15, Z);
    v(1, 6'h00, 6'h20, 0, 1, 4'd15, Z);
    v(0, 6'h00, 6'h20, 0, 1, 4'd0, F);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1, 100 + i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath, and the initiator side of the ALU interface. Each cycle it issues the 4-bit ALU operation code and operand selects, and consumes the ALU zero flag. It also sequences PC, IR, memory and register-file enables across fetch, decode, execute, memory and writeback. Supported instructions: R-type add/sub/and/or/slt, lw, sw, beq, j, addi.

Parameters:
ILLEGAL_TRAP, 0, 0 = illegal instruction pulses illegal and returns to FETCH; 1 = enter HALT and stay there until reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  from ALU: 1 when ALU result == 0
alu_ctl  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
alu_src_a  out  1  0 = PC, 1 = A register
alu_src_b  out  2  00 = B register, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC write enable
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register-file write enable
illegal  out  1  one-cycle pulse on an unsupported instruction
state  out  4  current state, for debug

Behaviour:
- Moore FSM with a registered 4-bit state. Outputs decode combinationally from state; EXEC additionally uses funct and BRANCH additionally uses zero.
- Reset: while reset = 1, every enable/strobe is 0, alu_ctl = 0000, all selects = 0, illegal = 0. The state register loads FETCH on the reset edge. The first cycle after reset deasserts is FETCH. A reset mid-instruction aborts it with no further writes.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, HALT 15.
- Any output not listed for a state is 0.
- FETCH: mem_read = 1, iord = 0, ir_write = 1, src_a = 0, src_b = 01, alu_ctl = add, pc_source = 00, pc_en = 1. Next state is DECODE.
- DECODE: src_a = 0, src_b = 11, alu_ctl = add (precomputes branch target). Next state by opcode:
  - 0x00 -> EXEC if funct is supported, else illegal
  - 0x23 / 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDIEX
  - anything else -> illegal
- Illegal path: illegal = 1 for this DECODE cycle only. Next state is FETCH if ILLEGAL_TRAP = 0, HALT if ILLEGAL_TRAP = 1.
- MEMADR: src_a = 1, src_b = 10, add. Next state is MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read = 1, iord = 1. Next state is MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next state is FETCH.
- MEMWR: mem_write = 1, iord = 1. Next state is FETCH.
- EXEC: src_a = 1, src_b = 00. funct maps to alu_ctl: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Next state is ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state is FETCH.
- BRANCH: src_a = 1, src_b = 00, sub, pc_source = 01, pc_en = zero. Next state is FETCH.
- JUMP: pc_source = 10, pc_en = 1. Next state is FETCH.
- ADDIEX: src_a = 1, src_b = 10, add. Next state is ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state is FETCH.
- HALT: all outputs 0; only reset exits.
- Cycles per instruction: beq/j 3, R-type/sw/addi 4, lw 5.
- Invariants:
  - Never more than one of {mem_write, reg_write, ir_write} high in a cycle.
  - mem_read and mem_write are never both high.
  - pc_en is high only in FETCH, JUMP, and BRANCH when zero = 1.
- Unused encodings 12–14 behave as FETCH on the next edge (recovery); outputs all 0 while in them.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - funct constants
  - ALU ctl codes (ALU_AND/OR/ADD/SUB/SLT)
  - state enum
  - src_b and pc_source select constants
- One sub-module: alu_ctl_decode, combinational funct -> {alu_ctl, funct_valid}. It is reused by DECODE for the legality check and by EXEC for the ALU code.

Test Plan:
- Reset held 2 cycles, released -> state = 0; FETCH outputs: mem_read = 1, ir_write = 1, pc_en = 1, alu_ctl = 0010, src_b = 01.
- lw (opcode 0x23) -> states 0,1,2,3,4,0. MEMRD has iord = 1, mem_read = 1. MEMWB has reg_write = 1, mem_to_reg = 1, reg_dst = 0. Total 5 cycles.
- R-type funct 0x2A then 0x22 -> EXEC alu_ctl = 0111, then 0110. ALUWB has reg_dst = 1, reg_write = 1. Each instruction takes 4 cycles.
- beq (0x04) with zero = 1, then again with zero = 0 -> BRANCH pc_en = 1 / pc_en = 0, pc_source = 01, alu_ctl = 0110 in both. Each takes 3 cycles.
- opcode 0x3F, and separately R-type funct 0x00 -> illegal = 1 for exactly one cycle in DECODE. Next state is FETCH with ILLEGAL_TRAP = 0; HALT (15) with ILLEGAL_TRAP = 1, held until reset.
- reset asserted during MEMWR -> that cycle's mem_write = 0. State is 0 on the next edge, and no write occurs.
